// File: rtl/qpu_dtcm_icb_arbiter.sv
// rtl/qpu_dtcm_icb_arbiter.sv - two-master round-robin ICB arbiter in front of the QPU DTCM port
module qpu_dtcm_icb_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int MW = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_icb_cmd_valid,
    output logic          m0_icb_cmd_ready,
    input  logic [AW-1:0] m0_icb_cmd_addr,
    input  logic          m0_icb_cmd_read,
    input  logic [DW-1:0] m0_icb_cmd_wdata,
    input  logic [MW-1:0] m0_icb_cmd_wmask,
    output logic          m0_icb_rsp_valid,
    input  logic          m0_icb_rsp_ready,
    output logic [DW-1:0] m0_icb_rsp_rdata,

    input  logic          m1_icb_cmd_valid,
    output logic          m1_icb_cmd_ready,
    input  logic [AW-1:0] m1_icb_cmd_addr,
    input  logic          m1_icb_cmd_read,
    input  logic [DW-1:0] m1_icb_cmd_wdata,
    input  logic [MW-1:0] m1_icb_cmd_wmask,
    output logic          m1_icb_rsp_valid,
    input  logic          m1_icb_rsp_ready,
    output logic [DW-1:0] m1_icb_rsp_rdata,

    output logic          dtcm_icb_cmd_valid,
    input  logic          dtcm_icb_cmd_ready,
    output logic [AW-1:0] dtcm_icb_cmd_addr,
    output logic          dtcm_icb_cmd_read,
    output logic [DW-1:0] dtcm_icb_cmd_wdata,
    output logic [MW-1:0] dtcm_icb_cmd_wmask,
    input  logic          dtcm_icb_rsp_valid,
    output logic          dtcm_icb_rsp_ready,
    input  logic [DW-1:0] dtcm_icb_rsp_rdata,

    output logic          arb_active,
    output logic          arb_err
);

    typedef enum logic {IDLE = 1'b0, WAIT_RSP = 1'b1} state_t;

    state_t state_q, state_d;
    logic   lock_q, lock_d;
    logic   owner_q, owner_d;
    logic   last_grant_q, last_grant_d;
    logic   arb_err_q, arb_err_d;
    logic   sel;
    logic   sel_valid;
    logic   owner_rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lock_q       <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            arb_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            arb_err_q    <= arb_err_d;
        end
    end

    // A stalled presentation locks the grant so the downstream command never changes under it
    always_comb begin
        sel = 1'b0;
        if (lock_q)
            sel = owner_q;
        else if (m0_icb_cmd_valid && m1_icb_cmd_valid)
            sel = ~last_grant_q;
        else if (m1_icb_cmd_valid)
            sel = 1'b1;
    end

    assign sel_valid       = sel ? m1_icb_cmd_valid : m0_icb_cmd_valid;
    assign owner_rsp_ready = owner_q ? m1_icb_rsp_ready : m0_icb_rsp_ready;

    always_comb begin
        state_d      = state_q;
        lock_d       = lock_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        arb_err_d    = arb_err_q;
        case (state_q)
            IDLE: begin
                if (dtcm_icb_rsp_valid)
                    arb_err_d = 1'b1;
                if (sel_valid) begin
                    owner_d = sel;
                    if (dtcm_icb_cmd_ready) begin
                        last_grant_d = sel;
                        lock_d       = 1'b0;
                        state_d      = WAIT_RSP;
                    end else begin
                        lock_d = 1'b1;
                    end
                end else begin
                    lock_d = 1'b0;
                end
            end
            WAIT_RSP: begin
                if (dtcm_icb_rsp_valid && owner_rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dtcm_icb_cmd_valid = 1'b0;
        dtcm_icb_cmd_addr  = sel ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
        dtcm_icb_cmd_read  = sel ? m1_icb_cmd_read  : m0_icb_cmd_read;
        dtcm_icb_cmd_wdata = sel ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
        dtcm_icb_cmd_wmask = sel ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
        m0_icb_cmd_ready   = 1'b0;
        m1_icb_cmd_ready   = 1'b0;
        m0_icb_rsp_valid   = 1'b0;
        m1_icb_rsp_valid   = 1'b0;
        m0_icb_rsp_rdata   = dtcm_icb_rsp_rdata;
        m1_icb_rsp_rdata   = dtcm_icb_rsp_rdata;
        dtcm_icb_rsp_ready = 1'b0;
        case (state_q)
            IDLE: begin
                dtcm_icb_cmd_valid = sel_valid;
                m0_icb_cmd_ready   = ~sel & dtcm_icb_cmd_ready;
                m1_icb_cmd_ready   = sel & dtcm_icb_cmd_ready;
                // Nothing is outstanding, so any response here is drained and flagged
                dtcm_icb_rsp_ready = 1'b1;
            end
            WAIT_RSP: begin
                m0_icb_rsp_valid   = ~owner_q & dtcm_icb_rsp_valid;
                m1_icb_rsp_valid   = owner_q & dtcm_icb_rsp_valid;
                dtcm_icb_rsp_ready = owner_rsp_ready;
            end
            default: ;
        endcase
    end

    assign arb_active = m0_icb_cmd_valid | m1_icb_cmd_valid | (state_q == WAIT_RSP);
    assign arb_err    = arb_err_q;

endmodule

// File: tb/tb_qpu_dtcm_icb_arbiter.sv
// tb/tb_qpu_dtcm_icb_arbiter.sv - randomized scoreboard bench for qpu_dtcm_icb_arbiter
module tb_qpu_dtcm_icb_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          m_valid     [2];
    logic [AW-1:0] m_addr      [2];
    logic          m_read      [2];
    logic [DW-1:0] m_wdata     [2];
    logic [MW-1:0] m_wmask     [2];
    logic          m_rsp_ready [2];
    logic          d_cmd_ready, d_rsp_valid;
    logic [DW-1:0] d_rsp_rdata;

    logic          m0_icb_cmd_ready, m1_icb_cmd_ready, m0_icb_rsp_valid, m1_icb_rsp_valid;
    logic [DW-1:0] m0_icb_rsp_rdata, m1_icb_rsp_rdata;
    logic          dtcm_icb_cmd_valid, dtcm_icb_cmd_read, dtcm_icb_rsp_ready;
    logic [AW-1:0] dtcm_icb_cmd_addr;
    logic [DW-1:0] dtcm_icb_cmd_wdata;
    logic [MW-1:0] dtcm_icb_cmd_wmask;
    logic          arb_active, arb_err;

    qpu_dtcm_icb_arbiter #(.AW(AW), .DW(DW), .MW(MW)) dut (
        .clk(clk), .rst(rst),
        .m0_icb_cmd_valid(m_valid[0]), .m0_icb_cmd_ready(m0_icb_cmd_ready),
        .m0_icb_cmd_addr(m_addr[0]), .m0_icb_cmd_read(m_read[0]),
        .m0_icb_cmd_wdata(m_wdata[0]), .m0_icb_cmd_wmask(m_wmask[0]),
        .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m_rsp_ready[0]),
        .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
        .m1_icb_cmd_valid(m_valid[1]), .m1_icb_cmd_ready(m1_icb_cmd_ready),
        .m1_icb_cmd_addr(m_addr[1]), .m1_icb_cmd_read(m_read[1]),
        .m1_icb_cmd_wdata(m_wdata[1]), .m1_icb_cmd_wmask(m_wmask[1]),
        .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m_rsp_ready[1]),
        .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
        .dtcm_icb_cmd_valid(dtcm_icb_cmd_valid), .dtcm_icb_cmd_ready(d_cmd_ready),
        .dtcm_icb_cmd_addr(dtcm_icb_cmd_addr), .dtcm_icb_cmd_read(dtcm_icb_cmd_read),
        .dtcm_icb_cmd_wdata(dtcm_icb_cmd_wdata), .dtcm_icb_cmd_wmask(dtcm_icb_cmd_wmask),
        .dtcm_icb_rsp_valid(d_rsp_valid), .dtcm_icb_rsp_ready(dtcm_icb_rsp_ready),
        .dtcm_icb_rsp_rdata(d_rsp_rdata),
        .arb_active(arb_active), .arb_err(arb_err)
    );

    typedef struct packed {
        logic          id;
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] ref_mem  [logic [AW-1:0]];
    logic [DW-1:0] dtcm_mem [logic [AW-1:0]];

    int n_chk  = 0;
    int n_pass = 0;

    bit mdl_wait = 0, mdl_hold = 0, mdl_hold_id = 0, mdl_last = 1, mdl_owner = 0;
    bit env_busy = 0;
    int env_delay = 0;
    logic [DW-1:0] env_data = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic logic [DW-1:0] dtcm_rd(input logic [AW-1:0] a);
        return dtcm_mem.exists(a) ? dtcm_mem[a] : '0;
    endfunction

    // Response monitor: every master-side response must match the oldest accepted command
    task automatic check_rsp(input logic id, input logic [DW-1:0] rdata, input logic rdy);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL rsp_unexpected: master %0d rsp_valid=1 required 0 at %0t", id, $time);
        end else begin
            e = exp_q[0];
            chk("rsp_owner", id, e.id);
            if (rdy) begin
                void'(exp_q.pop_front());
                if (e.rd) chk("rsp_rdata", rdata, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (m0_icb_rsp_valid) check_rsp(1'b0, m0_icb_rsp_rdata, m_rsp_ready[0]);
        if (m1_icb_rsp_valid) check_rsp(1'b1, m1_icb_rsp_rdata, m_rsp_ready[1]);
    end

    // One cycle of the reference model plus the downstream DTCM and master stimulus
    task automatic step(input int issue_pct, input int rdy_pct);
        int   p;
        bit   acc;
        exp_t e;
        @(negedge clk);
        p   = -1;
        acc = 0;
        if (!mdl_wait) begin
            if (mdl_hold)                       p = int'(mdl_hold_id);
            else if (m_valid[0] && m_valid[1])  p = mdl_last ? 0 : 1;
            else if (m_valid[0])                p = 0;
            else if (m_valid[1])                p = 1;
        end
        chk("arb_active", arb_active, m_valid[0] | m_valid[1] | mdl_wait);
        if (p >= 0)
            chk("cmd_path",
                {dtcm_icb_cmd_valid, dtcm_icb_cmd_addr, dtcm_icb_cmd_read, dtcm_icb_cmd_wdata,
                 dtcm_icb_cmd_wmask, m0_icb_cmd_ready, m1_icb_cmd_ready},
                {1'b1, m_addr[p], m_read[p], m_wdata[p], m_wmask[p],
                 d_cmd_ready && p == 0, d_cmd_ready && p == 1});
        else
            chk("cmd_quiet",
                {dtcm_icb_cmd_valid, mdl_wait ? {m0_icb_cmd_ready, m1_icb_cmd_ready} : 2'b00}, 0);
        if (mdl_wait && d_rsp_valid)
            chk("rsp_ready_route", dtcm_icb_rsp_ready, m_rsp_ready[mdl_owner]);

        if (mdl_wait) begin
            if (d_rsp_valid && m_rsp_ready[mdl_owner]) mdl_wait = 0;
        end else if (p >= 0) begin
            if (d_cmd_ready) begin
                e.id   = p[0];
                e.rd   = m_read[p];
                e.data = m_read[p] ? ref_rd(m_addr[p]) : '0;
                if (!m_read[p]) ref_mem[m_addr[p]] = merge(ref_rd(m_addr[p]), m_wdata[p], m_wmask[p]);
                exp_q.push_back(e);
                mdl_last  = p[0];
                mdl_owner = p[0];
                mdl_hold  = 0;
                mdl_wait  = 1;
                acc       = 1;
            end else begin
                mdl_hold    = 1;
                mdl_hold_id = p[0];
            end
        end else begin
            mdl_hold = 0;
        end

        if (d_rsp_valid && dtcm_icb_rsp_ready) env_busy = 0;
        if (dtcm_icb_cmd_valid && d_cmd_ready && !env_busy) begin
            env_busy  = 1;
            env_delay = int'($urandom_range(0, 2));
            if (dtcm_icb_cmd_read) begin
                env_data = dtcm_rd(dtcm_icb_cmd_addr);
            end else begin
                dtcm_mem[dtcm_icb_cmd_addr] = merge(dtcm_rd(dtcm_icb_cmd_addr), dtcm_icb_cmd_wdata,
                                                    dtcm_icb_cmd_wmask);
                env_data = '0;
            end
        end

        @(posedge clk);
        #1;
        if (acc) m_valid[p] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!m_valid[i] && int'($urandom_range(0, 99)) < issue_pct) begin
                m_valid[i] = 1'b1;
                m_addr[i]  = 16'h0010 + AW'(4 * $urandom_range(0, 3));
                m_read[i]  = 1'($urandom_range(0, 1));
                m_wdata[i] = $urandom;
                m_wmask[i] = MW'($urandom_range(1, 15));
            end
            m_rsp_ready[i] = int'($urandom_range(0, 99)) < rdy_pct;
        end
        d_cmd_ready = int'($urandom_range(0, 99)) < rdy_pct;
        if (env_busy && env_delay == 0) begin
            d_rsp_valid = 1'b1;
            d_rsp_rdata = env_data;
        end else begin
            if (env_busy) env_delay--;
            d_rsp_valid = 1'b0;
            d_rsp_rdata = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0; m_addr[i] = '0; m_read[i] = 1'b0;
            m_wdata[i] = '0; m_wmask[i] = '0; m_rsp_ready[i] = 1'b0;
        end
        d_cmd_ready = 1'b0; d_rsp_valid = 1'b0; d_rsp_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {dtcm_icb_cmd_valid, m0_icb_cmd_ready, m1_icb_cmd_ready,
                              m0_icb_rsp_valid, m1_icb_rsp_valid, arb_err, arb_active}, 0);

        tick();
        d_rsp_valid = 1'b1; d_rsp_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("spurious_drain", {dtcm_icb_rsp_ready, m0_icb_rsp_valid, m1_icb_rsp_valid, arb_err}, 4'b1000);
        tick();
        d_rsp_valid = 1'b0;
        @(negedge clk);
        chk("arb_err_set", arb_err, 1);
        repeat (3) tick();
        @(negedge clk);
        chk("arb_err_sticky", arb_err, 1);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("arb_err_cleared", arb_err, 0);

        tick();
        m_valid[1] = 1'b1; m_addr[1] = 16'h0020; m_read[1] = 1'b0;
        m_wdata[1] = 32'h12345678; m_wmask[1] = 4'hF; d_cmd_ready = 1'b1;
        @(negedge clk);
        chk("m1_only_grant", {dtcm_icb_cmd_valid, dtcm_icb_cmd_addr, dtcm_icb_cmd_wdata,
                              dtcm_icb_cmd_wmask, m1_icb_cmd_ready, m0_icb_cmd_ready},
            {1'b1, 16'h0020, 32'h12345678, 4'hF, 2'b10});
        exp_q.push_back('{id: 1'b1, rd: 1'b0, data: '0});
        tick();
        m_valid[1] = 1'b0;
        m_valid[0] = 1'b1; m_addr[0] = 16'h0030; m_read[0] = 1'b1;
        d_rsp_valid = 1'b1; d_rsp_rdata = '0; m_rsp_ready[1] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rsp_stall", {dtcm_icb_rsp_ready, m0_icb_cmd_ready, dtcm_icb_cmd_valid, m1_icb_rsp_valid}, 4'b0001);
            tick();
        end
        m_rsp_ready[1] = 1'b1;
        @(negedge clk);
        chk("rsp_release", {dtcm_icb_rsp_ready, dtcm_icb_cmd_valid}, 2'b10);
        tick();
        d_rsp_valid = 1'b0; m_rsp_ready[1] = 1'b0;
        @(negedge clk);
        chk("bubble_then_m0", {dtcm_icb_cmd_valid, dtcm_icb_cmd_addr, m0_icb_cmd_ready}, {1'b1, 16'h0030, 1'b1});
        tick();
        m_valid[0] = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("reset_in_wait", {m0_icb_rsp_valid, m1_icb_rsp_valid, arb_active}, 0);

        ref_mem[16'h0010]  = 32'hDEADBEEF;
        dtcm_mem[16'h0010] = 32'hDEADBEEF;
        tick();
        m_valid[0] = 1'b1; m_addr[0] = 16'h0010; m_read[0] = 1'b1;
        m_valid[1] = 1'b1; m_addr[1] = 16'h0014; m_read[1] = 1'b1;
        m_rsp_ready[0] = 1'b1; m_rsp_ready[1] = 1'b1; d_cmd_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("lock_hold", {dtcm_icb_cmd_valid, dtcm_icb_cmd_addr, m0_icb_cmd_ready, m1_icb_cmd_ready},
                {1'b1, 16'h0010, 2'b00});
            tick();
        end
        d_cmd_ready = 1'b1;
        mdl_hold = 1; mdl_hold_id = 0; mdl_last = 1; mdl_wait = 0; env_busy = 0;

        repeat (60)   step(100, 100);
        repeat (1500) step(40, 70);
        for (int k = 0; k < 200 && (mdl_wait || m_valid[0] || m_valid[1]); k++) step(0, 100);
        step(0, 100);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
